conv_reg_bank_seq: RTL and testbench
====================================

# conv_reg_bank_seq

Upstream fill-and-sweep stage for the 64-entry convolution register bank. It accepts a stream of 16-bit words over a valid/ready handshake and stores them in a 64x16 register bank, which it presents as the flat 1024-bit `Reg_Outs` bus. It then steps the 6-bit `MUX_Sel` through the loaded entries, so the downstream 64:1 word selector emits them one per accepted cycle. A replay command sweeps the stored bank again without reloading, for kernel/weight reuse.

## Interface
Parameters:
- `DATA_W`, 16: word width.
- `DEPTH`, 64: number of bank entries.
- `SEL_W`, 6: select width, equal to log2(`DEPTH`).

Ports:
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: reset, synchronous and active-high.
- `Start`, in, 1: begin a load; sampled only in IDLE.
- `Replay`, in, 1: sweep the stored bank again; sampled only in IDLE.
- `Load_Count`, in, 7: number of words to load, valid range 1..64; latched with `Start`.
- `In_Data`, in, 16: input word.
- `In_Valid`, in, 1: `In_Data` is valid.
- `In_Ready`, out, 1: block accepts a word this cycle.
- `Reg_Outs`, out, 1024: flat bank; entry i occupies bits [16i+15:16i].
- `MUX_Sel`, out, 6: index of the current sweep entry.
- `Sel_Valid`, out, 1: `MUX_Sel` (and therefore the downstream selector output) is valid.
- `Out_Ready`, in, 1: consumer accepts the current entry.
- `Busy`, out, 1: state is not IDLE.
- `Done`, out, 1: one-cycle pulse when a sweep completes.
- `Err`, out, 1: one-cycle pulse when a command is rejected.

## Operation
- FSM states: IDLE, LOAD, SWEEP.
- IDLE:
  - `Start` with `Load_Count` in 1..64: latch the count, clear `wr_ptr`, go to LOAD.
  - `Start` with `Load_Count` = 0 or > 64: pulse `Err`, stay in IDLE.
  - `Replay` with stored count ≠ 0: clear `rd_ptr`, go to SWEEP.
  - `Replay` with stored count = 0 (no load since reset): pulse `Err`, stay in IDLE.
  - `Start` and `Replay` asserted together: `Start` wins; `Replay` is ignored.
- LOAD:
  - `In_Ready` = 1.
  - On `In_Valid & In_Ready`: write `bank[wr_ptr]` ← `In_Data`, then increment `wr_ptr`.
  - On acceptance of word number count-1: go to SWEEP with `rd_ptr` = 0.
- SWEEP:
  - `Sel_Valid` = 1 and `MUX_Sel` = `rd_ptr`.
  - On `Out_Ready`: increment `rd_ptr`.
  - On acceptance of index count-1: go to IDLE and pulse `Done`.
- Bank writes occur only in LOAD.
- Entries at index ≥ count keep their previous contents; they are never swept.
- `Start`/`Replay` outside IDLE are ignored, with no `Err`.
- `In_Valid` outside LOAD is ignored and no word is written.
- `wr_ptr`/`rd_ptr` are 7 bits, compared against the count; `MUX_Sel` is `rd_ptr[5:0]`. A count of 64 ends at index 63 with no wrap.
- `Reg_Outs` is driven directly from bank flops, with no combinational path from inputs.

## Timing
- Reset values: state IDLE; every bank entry 0; stored count 0; `In_Ready` 0; `Sel_Valid` 0; `MUX_Sel` 0; `Busy` 0; `Done` 0; `Err` 0.
- Reset asserted mid-LOAD or mid-SWEEP: on the next edge everything returns to the reset values, including the bank.
- `Start` sampled at edge N: `In_Ready` = 1 and `Busy` = 1 from cycle N+1.
- Write timing: a word accepted at edge M is visible on `Reg_Outs` from cycle M+1.
- LOAD→SWEEP: the last word is accepted at edge M.
  - `In_Ready` = 0 from cycle M+1.
  - `Sel_Valid` = 1 with `MUX_Sel` = 0 from cycle M+1.
  - Bank contents are complete at M+1.
- Sweep rate: one entry per cycle while `Out_Ready` is held high; `MUX_Sel` holds while `Out_Ready` = 0.
- `Sel_Valid` does not depend on `Out_Ready`.
- End of sweep: the last entry is accepted at edge K.
  - `Sel_Valid` = 0, `Busy` = 0 and `Done` = 1 in cycle K+1 only.
  - `MUX_Sel` returns to 0 in cycle K+1.
- Minimum count-1 load: `Start`, one word, one sweep beat → `Done` 3 cycles after `Start` with `In_Valid`/`Out_Ready` held high.
- `Err` is asserted in the cycle after the offending command is sampled.
- A command is accepted again in the same cycle that `Done` is high.

## Test plan
- Reset, then `Start`, `Load_Count` = 64, words 0x1000+i with `In_Valid` = 1, `Out_Ready` = 1 → bank[i] = 0x1000+i; `MUX_Sel` steps 0..63 on consecutive cycles; `Done` pulses once, 64 cycles after the first `Sel_Valid`.
- `Load_Count` = 3 with `In_Valid` toggling every other cycle, then `Out_Ready` low for 2 cycles at index 1 → exactly 3 writes; `MUX_Sel` holds at 1 for 3 cycles; entries 3..63 unchanged.
- After a count-5 load, `Replay` → sweep 0..4 with bank unchanged; `Replay` straight after reset → `Err` pulse and `Busy` stays 0.
- `Start` with `Load_Count` = 0 and with 65 → `Err` pulse, state IDLE; `Start` and `Replay` together → LOAD entered and no `Err`.
- `rst` asserted after 10 of 20 words loaded → next cycle all `Reg_Outs` = 0, `In_Ready` = 0, `Busy` = 0; a subsequent `Replay` → `Err`.
- Count-1 load of 0xBEEF → bank[0] = 0xBEEF; `Done` 3 cycles after `Start`; `Start`/`In_Valid` pulsed during SWEEP have no effect.

Source files
------------

// File: rtl/conv_reg_bank_seq.sv
// conv_reg_bank_seq: fills a DEPTH x DATA_W register bank from a valid/ready
// word stream, then sweeps MUX_Sel over the loaded entries so a downstream
// word selector emits them one per accepted cycle. Replay re-sweeps the bank
// without reloading it.
module conv_reg_bank_seq #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 64,
    parameter int SEL_W  = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    Start,
    input  logic                    Replay,
    input  logic [SEL_W:0]          Load_Count,
    input  logic [DATA_W-1:0]       In_Data,
    input  logic                    In_Valid,
    output logic                    In_Ready,
    output logic [DEPTH*DATA_W-1:0] Reg_Outs,
    output logic [SEL_W-1:0]        MUX_Sel,
    output logic                    Sel_Valid,
    input  logic                    Out_Ready,
    output logic                    Busy,
    output logic                    Done,
    output logic                    Err
);

    // Pointers and count are one bit wider than the select so a full-depth
    // count is representable and the last index compares without wrapping.
    localparam int CNT_W = SEL_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] ONE_CNT   = CNT_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SWEEP
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic [CNT_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic             done_reg, done_next;
    logic             err_reg, err_next;
    logic             wr_en;
    logic [CNT_W-1:0] last_idx;

    assign last_idx = count_reg - ONE_CNT;

    // State, pointers, count and the one-cycle status pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            count_reg  <= '0;
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            done_reg   <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            count_reg  <= count_next;
            wr_ptr_reg <= wr_ptr_next;
            rd_ptr_reg <= rd_ptr_next;
            done_reg   <= done_next;
            err_reg    <= err_next;
        end
    end

    // Command decode, load stepping and sweep stepping.
    always_comb begin
        state_next  = state_reg;
        count_next  = count_reg;
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        done_next   = 1'b0;
        err_next    = 1'b0;
        wr_en       = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                // Start has priority; Replay is only looked at without Start.
                if (Start) begin
                    if (Load_Count != '0 && Load_Count <= DEPTH_CNT) begin
                        count_next  = Load_Count;
                        wr_ptr_next = '0;
                        state_next  = S_LOAD;
                    end else begin
                        err_next = 1'b1;
                    end
                end else if (Replay) begin
                    // A zero stored count means nothing was loaded since reset.
                    if (count_reg != '0) begin
                        rd_ptr_next = '0;
                        state_next  = S_SWEEP;
                    end else begin
                        err_next = 1'b1;
                    end
                end
            end
            S_LOAD: begin
                if (In_Valid) begin
                    wr_en       = 1'b1;
                    wr_ptr_next = wr_ptr_reg + ONE_CNT;
                    if (wr_ptr_reg == last_idx) begin
                        rd_ptr_next = '0;
                        state_next  = S_SWEEP;
                    end
                end
            end
            S_SWEEP: begin
                if (Out_Ready) begin
                    if (rd_ptr_reg == last_idx) begin
                        // Park the select at 0 so IDLE always shows index 0.
                        rd_ptr_next = '0;
                        done_next   = 1'b1;
                        state_next  = S_IDLE;
                    end else begin
                        rd_ptr_next = rd_ptr_reg + ONE_CNT;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // One flop word per entry, driven straight onto its slice of Reg_Outs.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_bank
            logic [DATA_W-1:0] entry_reg;

            // Capture the incoming word only when this entry is the write target.
            always_ff @(posedge clk) begin
                if (rst) begin
                    entry_reg <= '0;
                end else if (wr_en && wr_ptr_reg[SEL_W-1:0] == SEL_W'(gi)) begin
                    entry_reg <= In_Data;
                end
            end

            assign Reg_Outs[gi*DATA_W +: DATA_W] = entry_reg;
        end
    endgenerate

    assign In_Ready  = (state_reg == S_LOAD);
    assign Sel_Valid = (state_reg == S_SWEEP);
    assign Busy      = (state_reg != S_IDLE);
    assign MUX_Sel   = rd_ptr_reg[SEL_W-1:0];
    assign Done      = done_reg;
    assign Err       = err_reg;

endmodule

// File: tb/tb_conv_reg_bank_seq.sv
// Testbench for conv_reg_bank_seq: directed stimulus pushes expected sweep
// beats and Done/Err events into queues; a monitor pops and compares them.
module tb_conv_reg_bank_seq;

    logic          clk = 1'b0;
    logic          rst;
    logic          Start, Replay;
    logic [6:0]    Load_Count;
    logic [15:0]   In_Data;
    logic          In_Valid;
    logic          In_Ready;
    logic [1023:0] Reg_Outs;
    logic [5:0]    MUX_Sel;
    logic          Sel_Valid;
    logic          Out_Ready;
    logic          Busy, Done, Err;

    conv_reg_bank_seq dut (
        .clk        (clk),
        .rst        (rst),
        .Start      (Start),
        .Replay     (Replay),
        .Load_Count (Load_Count),
        .In_Data    (In_Data),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .Reg_Outs   (Reg_Outs),
        .MUX_Sel    (MUX_Sel),
        .Sel_Valid  (Sel_Valid),
        .Out_Ready  (Out_Ready),
        .Busy       (Busy),
        .Done       (Done),
        .Err        (Err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  sel;
        logic [15:0] data;
    } beat_t;

    localparam logic [1:0] EV_DONE = 2'b10;
    localparam logic [1:0] EV_ERR  = 2'b01;

    beat_t      beat_q[$];
    logic [1:0] evt_q[$];
    int         n_cmp = 0;
    int         n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ent(input int i);
        return Reg_Outs[i*16 +: 16];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_beat(input int sel, input logic [15:0] data);
        beat_t b;
        b.sel  = 6'(sel);
        b.data = data;
        beat_q.push_back(b);
    endtask

    // Advance until Done is seen; reports cycles taken, or flags a timeout.
    task automatic wait_done(output int cycles);
        cycles = -1;
        for (int c = 1; c <= 300; c++) begin
            tick();
            if (Done) begin
                cycles = c;
                break;
            end
        end
        if (cycles < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_done: Done never seen within 300 cycles");
        end
    endtask

    // Monitor: each accepted sweep beat and each Done/Err pulse is matched
    // against the next expectation in its queue.
    initial begin
        logic [1:0] code;
        beat_t      b;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (Sel_Valid && Out_Ready) begin
                    if (beat_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL beat: unexpected beat sel=%0d data=%h", MUX_Sel, ent(int'(MUX_Sel)));
                    end else begin
                        b = beat_q.pop_front();
                        $display("beat sel=%0d data=%h (exp sel=%0d data=%h)", MUX_Sel, ent(int'(MUX_Sel)), b.sel, b.data);
                        chk("beat_sel", 32'(MUX_Sel), 32'(b.sel));
                        chk("beat_data", 32'(ent(int'(MUX_Sel))), 32'(b.data));
                    end
                end
                if (Done || Err) begin
                    code = {Done, Err};
                    if (evt_q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL event: unexpected Done=%0b Err=%0b", Done, Err);
                    end else begin
                        $display("event Done=%0b Err=%0b", Done, Err);
                        chk("event", 32'(code), 32'(evt_q.pop_front()));
                    end
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        rst = 1'b1; Start = 1'b0; Replay = 1'b0; Load_Count = '0;
        In_Data = '0; In_Valid = 1'b0; Out_Ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", 32'(In_Ready), 0);
        chk("rst_sel_valid", 32'(Sel_Valid), 0);
        chk("rst_mux_sel", 32'(MUX_Sel), 0);
        chk("rst_busy", 32'(Busy), 0);
        chk("rst_done", 32'(Done), 0);
        chk("rst_err", 32'(Err), 0);
        chk("rst_bank_zero", 32'(Reg_Outs == '0), 1);

        // Replay with nothing loaded -> Err, stays idle
        evt_q.push_back(EV_ERR);
        Replay = 1'b1;
        tick();
        Replay = 1'b0;
        chk("replay_empty_err", 32'(Err), 1);
        chk("replay_empty_busy", 32'(Busy), 0);

        // Out-of-range counts -> Err
        evt_q.push_back(EV_ERR);
        Start = 1'b1; Load_Count = 7'd0;
        tick();
        Start = 1'b0;
        chk("cnt0_err", 32'(Err), 1);
        chk("cnt0_busy", 32'(Busy), 0);
        evt_q.push_back(EV_ERR);
        Start = 1'b1; Load_Count = 7'd65;
        tick();
        Start = 1'b0;
        chk("cnt65_err", 32'(Err), 1);
        chk("cnt65_busy", 32'(Busy), 0);
        tick();

        // Full 64-entry load, continuous sweep
        for (int i = 0; i < 64; i++) push_beat(i, 16'h1000 + 16'(i));
        evt_q.push_back(EV_DONE);
        Out_Ready = 1'b1;
        Start = 1'b1; Load_Count = 7'd64;
        tick();
        Start = 1'b0;
        chk("load64_in_ready", 32'(In_Ready), 1);
        chk("load64_busy", 32'(Busy), 1);
        for (int i = 0; i < 64; i++) begin
            In_Valid = 1'b1;
            In_Data  = 16'h1000 + 16'(i);
            tick();
        end
        In_Valid = 1'b0;
        chk("load64_ready_drop", 32'(In_Ready), 0);
        chk("load64_sel_valid", 32'(Sel_Valid), 1);
        chk("load64_sel0", 32'(MUX_Sel), 0);
        wait_done(cyc);
        chk("load64_done_latency", 32'(cyc), 64);
        chk("load64_done_selv", 32'(Sel_Valid), 0);
        chk("load64_done_busy", 32'(Busy), 0);
        chk("load64_done_sel", 32'(MUX_Sel), 0);
        for (int i = 0; i < 64; i++) chk("load64_bank", 32'(ent(i)), 32'h1000 + 32'(i));

        // Count-3 load with gappy In_Valid, Out_Ready stalls at index 1
        for (int i = 0; i < 3; i++) push_beat(i, 16'hA000 + 16'(i));
        evt_q.push_back(EV_DONE);
        Start = 1'b1; Load_Count = 7'd3;
        tick();
        Start = 1'b0;
        begin
            int sent = 0;
            bit v = 1'b1;
            for (int c = 0; c < 20 && sent < 3; c++) begin
                In_Valid = v;
                In_Data  = 16'hA000 + 16'(sent);
                tick();
                if (v) sent++;
                v = ~v;
            end
        end
        In_Valid = 1'b0;
        chk("cnt3_sel_valid", 32'(Sel_Valid), 1);
        chk("cnt3_sel0", 32'(MUX_Sel), 0);
        tick();
        Out_Ready = 1'b0;
        chk("cnt3_hold_a", 32'(MUX_Sel), 1);
        tick();
        chk("cnt3_hold_b", 32'(MUX_Sel), 1);
        tick();
        Out_Ready = 1'b1;
        chk("cnt3_hold_c", 32'(MUX_Sel), 1);
        tick();
        chk("cnt3_sel2", 32'(MUX_Sel), 2);
        tick();
        chk("cnt3_done", 32'(Done), 1);
        for (int i = 0; i < 3; i++) chk("cnt3_bank_new", 32'(ent(i)), 32'hA000 + 32'(i));
        for (int i = 3; i < 64; i++) chk("cnt3_bank_kept", 32'(ent(i)), 32'h1000 + 32'(i));

        // Count-5 load, then Replay in the Done cycle
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 5; i++) push_beat(i, 16'hC000 + 16'(i));
        evt_q.push_back(EV_DONE);
        evt_q.push_back(EV_DONE);
        Start = 1'b1; Load_Count = 7'd5;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            In_Valid = 1'b1;
            In_Data  = 16'hC000 + 16'(i);
            tick();
        end
        In_Valid = 1'b0;
        wait_done(cyc);
        chk("cnt5_sweep_len", 32'(cyc), 5);
        Replay = 1'b1;
        tick();
        Replay = 1'b0;
        chk("replay_sel_valid", 32'(Sel_Valid), 1);
        chk("replay_busy", 32'(Busy), 1);
        chk("replay_in_ready", 32'(In_Ready), 0);
        wait_done(cyc);
        chk("replay_sweep_len", 32'(cyc), 5);
        for (int i = 0; i < 5; i++) chk("replay_bank", 32'(ent(i)), 32'hC000 + 32'(i));
        chk("replay_bank_kept", 32'(ent(5)), 32'h1005);

        // Start and Replay together: Start wins, no Err
        push_beat(0, 16'hD000);
        push_beat(1, 16'hD001);
        evt_q.push_back(EV_DONE);
        Start = 1'b1; Replay = 1'b1; Load_Count = 7'd2;
        tick();
        Start = 1'b0; Replay = 1'b0;
        chk("both_in_ready", 32'(In_Ready), 1);
        chk("both_no_err", 32'(Err), 0);
        for (int i = 0; i < 2; i++) begin
            In_Valid = 1'b1;
            In_Data  = 16'hD000 + 16'(i);
            tick();
        end
        In_Valid = 1'b0;
        wait_done(cyc);
        chk("both_sweep_len", 32'(cyc), 2);

        // Reset in the middle of a 20-word load
        Start = 1'b1; Load_Count = 7'd20;
        tick();
        Start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            In_Valid = 1'b1;
            In_Data  = 16'hE000 + 16'(i);
            tick();
        end
        chk("midload_bank9", 32'(ent(9)), 32'hE009);
        In_Valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("midrst_bank_zero", 32'(Reg_Outs == '0), 1);
        chk("midrst_in_ready", 32'(In_Ready), 0);
        chk("midrst_busy", 32'(Busy), 0);
        chk("midrst_sel_valid", 32'(Sel_Valid), 0);
        evt_q.push_back(EV_ERR);
        Replay = 1'b1;
        tick();
        Replay = 1'b0;
        chk("midrst_replay_err", 32'(Err), 1);
        chk("midrst_replay_busy", 32'(Busy), 0);
        tick();

        // Count-1 load; Start/In_Valid during SWEEP are ignored
        push_beat(0, 16'hBEEF);
        evt_q.push_back(EV_DONE);
        Out_Ready = 1'b1;
        Start = 1'b1; Load_Count = 7'd1; In_Valid = 1'b1; In_Data = 16'hBEEF;
        tick();
        Start = 1'b0;
        chk("one_in_ready", 32'(In_Ready), 1);
        tick();
        chk("one_sweep", 32'(Sel_Valid), 1);
        Start = 1'b1; Load_Count = 7'd2; In_Data = 16'h5555;
        tick();
        Start = 1'b0; In_Valid = 1'b0;
        chk("one_done_3cyc", 32'(Done), 1);
        chk("one_done_busy", 32'(Busy), 0);
        chk("one_bank0", 32'(ent(0)), 32'hBEEF);
        chk("one_bank1", 32'(ent(1)), 32'h0000);
        tick();
        chk("one_idle_after", 32'(Busy), 0);
        tick();
        tick();

        chk("beats_outstanding", 32'(beat_q.size()), 0);
        chk("events_outstanding", 32'(evt_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
